// File: rtl/uart_receiver.sv
// uart_receiver: oversampled asynchronous serial receiver (start, DATA_BITS
// data bits LSB first, one stop bit). Everything runs in the clk domain; bit
// timing comes from an internal tick enable that fires OVERSAMPLE times per
// bit period.
module uart_receiver #(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUDRATE   = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned DIV  = CLK_FREQ / (BAUDRATE * OVERSAMPLE);
  localparam int unsigned TCW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SCW  = $clog2(OVERSAMPLE);
  localparam int unsigned BCW  = $clog2(DATA_BITS + 1);

  localparam logic [TCW-1:0] TICK_LAST = TCW'(DIV - 1);
  localparam logic [SCW-1:0] SAMP_MID  = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] SAMP_LAST = SCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BITS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  if (DIV < 2) begin : g_div_check
    $error("uart_receiver: CLK_FREQ/(BAUDRATE*OVERSAMPLE) must be at least 2");
  end
  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_os_check
    $error("uart_receiver: OVERSAMPLE must be even and >= 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_db_check
    $error("uart_receiver: DATA_BITS must be in 5..9");
  end

  logic                 rx_meta;
  logic                 rx_s;
  logic                 rx_prev;
  logic [1:0]           state;
  logic [TCW-1:0]       tick_cnt;
  logic                 tick;
  logic [SCW-1:0]       samp_cnt;
  logic [BCW-1:0]       bit_cnt;
  logic [DATA_BITS-1:0] shift;

  // Two-flop synchronizer plus previous-sample flop for falling-edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign tick = (state != IDLE) && (tick_cnt == TICK_LAST);

  // Oversampling tick divider, held at zero while idle so the first tick
  // after a start edge lands a fixed DIV clocks later
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Frame state machine, shift register and one-cycle output strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      samp_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          samp_cnt <= '0;
          bit_cnt  <= '0;
          if (!rx_s && rx_prev) begin
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            if (samp_cnt == SAMP_MID) begin
              samp_cnt <= '0;
              state    <= rx_s ? IDLE : DATA;
            end else begin
              samp_cnt <= samp_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (samp_cnt == SAMP_LAST) begin
              shift    <= {rx_s, shift[DATA_BITS-1:1]};
              samp_cnt <= '0;
              if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
                state   <= STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              samp_cnt <= samp_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (samp_cnt == SAMP_LAST) begin
              if (rx_s) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
              samp_cnt <= '0;
              state    <= IDLE;
            end else begin
              samp_cnt <= samp_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scoreboard bench for uart_receiver at DIV=4, 64 clk/bit.
module tb_uart_receiver;

  localparam int BIT = 64;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  uart_receiver #(
    .CLK_FREQ  (640000),
    .BAUDRATE  (10000),
    .OVERSAMPLE(16),
    .DATA_BITS (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         cyc = 0;
  int         vectors = 0;
  int         errors = 0;
  int         last_valid_cyc = -1;
  logic       prev_pulse = 1'b0;
  logic [7:0] last_data = 8'h00;
  logic [8:0] sb[$];

  always @(posedge clk) cyc++;

  // Output monitor: every strobe is checked against the scoreboard head
  always @(negedge clk) begin
    logic [8:0] exp_v;
    logic [8:0] got_v;
    if (rx_valid || frame_err) begin
      vectors++;
      if (rx_valid && frame_err) begin
        errors++;
        $display("FAIL both_pulses rx_valid=%b frame_err=%b, required not both high", rx_valid, frame_err);
      end
      vectors++;
      if (prev_pulse) begin
        errors++;
        $display("FAIL consecutive_pulse at cycle %0d, required single-cycle strobe", cyc);
      end
      vectors++;
      got_v = {frame_err, rx_data};
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse err=%b data=%h at cycle %0d, required no pulse", frame_err, rx_data, cyc);
      end else begin
        exp_v = sb.pop_front();
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL pulse_content got err=%b data=%h, required err=%b data=%h",
                   got_v[8], got_v[7:0], exp_v[8], exp_v[7:0]);
        end
      end
      if (rx_valid) last_valid_cyc = cyc;
    end
    prev_pulse = rx_valid || frame_err;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int bl);
    rx = 1'b0;
    wait_clk(bl);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clk(bl);
    end
    rx = stop_bit;
    wait_clk(bl);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    wait_clk(n * BIT);
  endtask

  task automatic drain_check(input string name);
    wait_clk(100);
    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_pulses pending=%0d, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_zero_outputs(input string name);
    vectors++;
    if (rx_data !== 8'h00) begin
      errors++;
      $display("FAIL %s_rx_data got %h, required 00", name, rx_data);
    end
    vectors++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_rx_valid got %b, required 0", name, rx_valid);
    end
    vectors++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL %s_frame_err got %b, required 0", name, frame_err);
    end
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy got %b, required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    check_zero_outputs("reset");
    last_data = 8'h00;
  endtask

  task automatic test_single();
    int start_cyc;
    int lat;
    idle_bits(10);
    sb.push_back({1'b0, 8'hA5});
    start_cyc = cyc;
    last_valid_cyc = -1;
    fork
      send_frame(8'hA5, 1'b1, BIT);
      begin
        wait_clk(200);
        vectors++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL single_busy_mid got %b, required 1", busy);
        end
      end
    join
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_end got %b, required 0", busy);
    end
    lat = last_valid_cyc - start_cyc;
    vectors++;
    if (last_valid_cyc < 0 || lat < 606 || lat > 614) begin
      errors++;
      $display("FAIL single_latency got %0d clk, required 606..614", lat);
    end
    last_data = 8'hA5;
    drain_check("single");
  endtask

  task automatic test_back_to_back();
    idle_bits(2);
    sb.push_back({1'b0, 8'h00});
    sb.push_back({1'b0, 8'hFF});
    send_frame(8'h00, 1'b1, BIT);
    send_frame(8'hFF, 1'b1, BIT);
    last_data = 8'hFF;
    drain_check("b2b");
  endtask

  task automatic test_false_start();
    logic seen;
    int   k;
    idle_bits(2);
    seen = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    rx = 1'b1;
    k = 0;
    while (busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    vectors++;
    if (seen !== 1'b1) begin
      errors++;
      $display("FAIL false_start_busy_seen got %b, required 1", seen);
    end
    vectors++;
    if (busy !== 1'b0 || (20 + k) < 31 || (20 + k) > 36) begin
      errors++;
      $display("FAIL false_start_busy_release busy=%b after %0d clk, required 0 within 31..36", busy, 20 + k);
    end
    idle_bits(2);
    drain_check("false_start");
  endtask

  task automatic test_frame_err();
    idle_bits(2);
    sb.push_back({1'b1, last_data});
    send_frame(8'h3C, 1'b0, BIT);
    rx = 1'b0;
    wait_clk(3 * BIT);
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_err_line_low_busy got %b, required 0", busy);
    end
    idle_bits(2);
    sb.push_back({1'b0, 8'h81});
    send_frame(8'h81, 1'b1, BIT);
    last_data = 8'h81;
    drain_check("frame_err");
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    idle_bits(2);
    d = 8'h5A;
    rx = 1'b0;
    wait_clk(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      wait_clk(BIT);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    check_zero_outputs("midreset");
    last_data = 8'h00;
    idle_bits(2);
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle_busy got %b, required 0", busy);
    end
    sb.push_back({1'b0, 8'h5A});
    send_frame(8'h5A, 1'b1, BIT);
    last_data = 8'h5A;
    drain_check("midreset");
  endtask

  task automatic test_baud_tolerance();
    int rates[2] = '{62, 66};
    foreach (rates[r]) begin
      idle_bits(2);
      sb.push_back({1'b0, 8'h55});
      sb.push_back({1'b0, 8'hC3});
      send_frame(8'h55, 1'b1, rates[r]);
      send_frame(8'hC3, 1'b1, rates[r]);
      rx = 1'b1;
      drain_check("baud");
    end
    last_data = 8'hC3;
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_false_start();
    test_frame_err();
    test_reset_midframe();
    test_baud_tolerance();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
